// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory load responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_t;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_byte_assembler.sv
// Assembles big-endian program bytes into 32-bit words. A word is emitted
// combinationally with the 4th accepted byte, or early with zero fill when
// the final byte of the program arrives mid-word (flagged by partial_o).
module imem_byte_assembler
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  input  logic        last_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic        partial_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] joined;
  logic [4:0]  fill_sh;

  // Word output: bytes received so far plus the current byte, left-aligned
  // so that unreceived trailing bytes read as zero.
  always_comb begin
    joined       = {shift_q, byte_i};
    fill_sh      = {2'(LAST_IDX - idx_q), 3'b000};
    word_o       = joined << fill_sh;
    word_valid_o = byte_valid_i && ((idx_q == LAST_IDX) || last_i);
    partial_o    = byte_valid_i && last_i && (idx_q != LAST_IDX);
  end

  // Next byte index and shift contents; a restart discards any partial word.
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear_i || word_valid_o) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {shift_q[15:0], byte_i};
    end
  end

  // Byte index and shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_load_responder.sv
// Instruction memory for the single-cycle datapath: registered fetch port
// plus a byte-serial program loader that holds the core while loading.
// Optional feature macro: IMEM_CHECKSUM_EN (XOR checksum of written words).
// Handshake: a loader byte transfers on a rising edge where ld_valid and
// ld_ready are both 1; ld_ready is 1 exactly while the FSM is in LOAD, and a
// byte offered in the same cycle as ld_start is not taken.
module imem_load_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              core_hold,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_done,
  output logic              ld_err,
  output logic [ADDR_W:0]   ld_words,
  output logic [DATA_W-1:0] ld_checksum
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  ld_state_t         state_q, state_d;
  logic [ADDR_W:0]   words_q;
  logic              err_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              byte_acc;
  logic              word_valid;
  logic [31:0]       word;
  logic              partial;
  logic              room;
  logic              wr_en;
  logic              pc_ok;

  assign ld_ready = (state_q == LOAD);
  assign byte_acc = ld_valid && ld_ready && !ld_start;
  assign room     = (words_q < DEPTH_W);
  assign wr_en    = word_valid && room;
  assign pc_ok    = ({1'b0, pc} < DEPTH_W);

  imem_byte_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (ld_start),
    .byte_valid_i (byte_acc),
    .byte_i       (ld_byte),
    .last_i       (ld_last),
    .word_valid_o (word_valid),
    .word_o       (word),
    .partial_o    (partial)
  );

  // Loader FSM next state and the hold/done outputs it drives.
  always_comb begin
    state_d   = state_q;
    core_hold = 1'b0;
    ld_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_start) state_d = LOAD;
      end
      LOAD: begin
        core_hold = 1'b1;
        if (ld_start)                state_d = LOAD;
        else if (byte_acc && ld_last) state_d = DONE;
      end
      DONE: begin
        core_hold = 1'b1;
        ld_done   = 1'b1;
        state_d   = ld_start ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Loader FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Word count (doubles as write address) and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      err_q   <= 1'b0;
    end else if (ld_start) begin
      words_q <= '0;
      err_q   <= 1'b0;
    end else if (word_valid) begin
      if (room) words_q <= words_q + 1'b1;
      else      err_q   <= 1'b1;
      if (partial) err_q <= 1'b1;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  // Running XOR of every word actually written to memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        csum_q <= '0;
    else if (ld_start) csum_q <= '0;
    else if (wr_en)    csum_q <= csum_q ^ DATA_W'(word);
  end

  assign ld_checksum = csum_q;
`else
  assign ld_checksum = '0;
`endif

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[words_q[IDX_W-1:0]] <= DATA_W'(word);
  end

  // Registered fetch; a same-edge write is not seen until the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     instr_q <= DATA_W'(NOP_INSTR);
    else if (pc_ok) instr_q <= mem_q[pc[IDX_W-1:0]];
    else            instr_q <= DATA_W'(NOP_INSTR);
  end

  assign ld_err   = err_q;
  assign ld_words = words_q;
  assign instr    = core_hold ? DATA_W'(NOP_INSTR) : instr_q;

endmodule

// File: tb/tb_imem_load_responder.sv
// Self-checking bench for imem_load_responder (build with or without
// IMEM_CHECKSUM_EN). A second, 128-word instance covers out-of-range fetch.
module tb_imem_load_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pc = '0;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic [31:0] instr, ld_checksum;
  logic        core_hold, ld_ready, ld_done, ld_err;
  logic [8:0]  ld_words;
  logic [31:0] s_instr, s_checksum;
  logic        s_hold, s_ready, s_done, s_err;
  logic [8:0]  s_words;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [256];
  logic [31:0] exp_w, got_w;

  imem_load_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .core_hold(core_hold),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_done(ld_done), .ld_err(ld_err),
    .ld_words(ld_words), .ld_checksum(ld_checksum)
  );

  imem_load_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(128)) u_small (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(s_instr), .core_hold(s_hold),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(s_ready),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_done(s_done), .ld_err(s_err),
    .ld_words(s_words), .ld_checksum(s_checksum)
  );

  // clock / done-pulse monitor
  always #5 clk = ~clk;
  always @(negedge clk) if (ld_done === 1'b1) done_cnt++;

  function automatic logic [31:0] exp_csum(input logic [31:0] v);
`ifdef IMEM_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // ---------------- driver tasks (start and end on a falling edge) --------
  task automatic start_load();
    ld_start = 1'b1;
    @(posedge clk); @(negedge clk);
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    while (ld_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL ld_ready_timeout got %b exp 1", ld_ready);
    end
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    @(posedge clk); @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[7:0],   last);
  endtask

  task automatic finish_load();
    @(posedge clk); @(negedge clk);
  endtask

  // Scoreboarded fetch: expectation queued when pc is driven, popped when
  // instr is due one cycle later.
  task automatic check_fetch(input string name, input logic [7:0] a);
    pc = a;
    exp_q.push_back(model_mem[a]);
    @(posedge clk); @(negedge clk);
    exp_w = exp_q.pop_front();
    checks++;
    if (instr !== exp_w) begin
      errors++; $display("FAIL %s got %h exp %h", name, instr, exp_w);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({instr, core_hold, ld_ready, ld_done, ld_err, ld_words, ld_checksum} !== '0) begin
      errors++;
      $display("FAIL reset_values got instr=%h hold=%b rdy=%b done=%b err=%b words=%0d csum=%h exp all 0",
               instr, core_hold, ld_ready, ld_done, ld_err, ld_words, ld_checksum);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    int d0;
    d0 = done_cnt;
    pc = 8'd0;
    start_load();
    checks++;
    if (core_hold !== 1'b1 || ld_ready !== 1'b1 || instr !== 32'h0) begin
      errors++; $display("FAIL load_hold got hold=%b rdy=%b instr=%h exp 1 1 0", core_hold, ld_ready, instr);
    end
    send_word(32'h20080005, 1'b0);
    send_word(32'h8C010004, 1'b1);
    model_mem[0] = 32'h20080005;
    model_mem[1] = 32'h8C010004;
    finish_load();
    checks++;
    if (ld_words !== 9'd2) begin errors++; $display("FAIL basic_words got %0d exp 2", ld_words); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got %0d exp 1", done_cnt - d0); end
    checks++;
    if (ld_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", ld_err); end
    checks++;
    if (core_hold !== 1'b0) begin errors++; $display("FAIL basic_hold_after got %b exp 0", core_hold); end
    checks++;
    if (ld_checksum !== exp_csum(32'hAC090001)) begin
      errors++; $display("FAIL basic_checksum got %h exp %h", ld_checksum, exp_csum(32'hAC090001));
    end
  endtask

  task automatic test_fetch();
    check_fetch("fetch_pc1", 8'd1);
    check_fetch("fetch_pc0", 8'd0);
    pc = 8'd200;
    @(posedge clk); @(negedge clk);
    checks++;
    if (s_instr !== 32'h0) begin errors++; $display("FAIL fetch_out_of_range got %h exp 0", s_instr); end
    pc = 8'd1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (s_instr !== 32'h8C010004) begin errors++; $display("FAIL small_fetch_pc1 got %h exp 8c010004", s_instr); end
  endtask

  task automatic test_partial();
    start_load();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    model_mem[0] = 32'hAABBCC00;
    finish_load();
    checks++;
    if (ld_err !== 1'b1) begin errors++; $display("FAIL partial_err got %b exp 1", ld_err); end
    checks++;
    if (ld_words !== 9'd1) begin errors++; $display("FAIL partial_words got %0d exp 1", ld_words); end
    checks++;
    if (ld_checksum !== exp_csum(32'hAABBCC00)) begin
      errors++; $display("FAIL partial_checksum got %h exp %h", ld_checksum, exp_csum(32'hAABBCC00));
    end
    check_fetch("partial_mem0", 8'd0);
  endtask

  task automatic test_overflow();
    int d0;
    logic [31:0] w, cs;
    d0 = done_cnt;
    cs = '0;
    start_load();
    for (int i = 0; i < 256; i++) begin
      w = {8'hA5, 8'(i), ~8'(i), 8'(i) ^ 8'h3C};
      send_word(w, 1'b0);
      model_mem[i] = w;
      cs ^= w;
    end
    checks++;
    if (ld_words !== 9'd256 || ld_err !== 1'b0) begin
      errors++; $display("FAIL full_no_err got words=%0d err=%b exp 256 0", ld_words, ld_err);
    end
    send_word(32'h0BADF00D, 1'b1);
    finish_load();
    checks++;
    if (ld_words !== 9'd256) begin errors++; $display("FAIL overflow_words got %0d exp 256", ld_words); end
    checks++;
    if (ld_err !== 1'b1) begin errors++; $display("FAIL overflow_err got %b exp 1", ld_err); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL overflow_done got %0d exp 1", done_cnt - d0); end
    checks++;
    if (ld_checksum !== exp_csum(cs)) begin
      errors++; $display("FAIL overflow_checksum got %h exp %h", ld_checksum, exp_csum(cs));
    end
    check_fetch("overflow_mem0", 8'd0);
    check_fetch("overflow_mem255", 8'd255);
    check_fetch("overflow_mem128", 8'd128);
  endtask

  task automatic test_restart_and_reset();
    start_load();
    send_word(32'h11223344, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    checks++;
    if (ld_words !== 9'd1) begin errors++; $display("FAIL pre_restart_words got %0d exp 1", ld_words); end
    start_load();
    checks++;
    if (ld_words !== 9'd0 || ld_err !== 1'b0 || core_hold !== 1'b1) begin
      errors++; $display("FAIL restart_clear got words=%0d err=%b hold=%b exp 0 0 1", ld_words, ld_err, core_hold);
    end
    send_word(32'hDEADBEEF, 1'b1);
    model_mem[0] = 32'hDEADBEEF;
    finish_load();
    checks++;
    if (ld_words !== 9'd1 || ld_err !== 1'b0) begin
      errors++; $display("FAIL restart_result got words=%0d err=%b exp 1 0", ld_words, ld_err);
    end
    checks++;
    if (ld_checksum !== exp_csum(32'hDEADBEEF)) begin
      errors++; $display("FAIL restart_checksum got %h exp %h", ld_checksum, exp_csum(32'hDEADBEEF));
    end
    check_fetch("restart_mem0", 8'd0);

    // Asynchronous reset in the middle of a load.
    pc = 8'd0;
    start_load();
    send_word(32'hCAFEF00D, 1'b0);
    send_byte(8'h77, 1'b0);
    model_mem[0] = 32'hCAFEF00D;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({instr, core_hold, ld_ready, ld_done, ld_err, ld_words, ld_checksum} !== '0) begin
      errors++;
      $display("FAIL async_reset got instr=%h hold=%b rdy=%b done=%b err=%b words=%0d csum=%h exp all 0",
               instr, core_hold, ld_ready, ld_done, ld_err, ld_words, ld_checksum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_fetch("reset_keeps_mem0", 8'd0);
    got_w = ld_words;
    checks++;
    if (ld_ready !== 1'b0 || core_hold !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got rdy=%b hold=%b exp 0 0", ld_ready, core_hold);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_fetch();
    test_partial();
    test_overflow();
    test_restart_and_reset();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
